if_stage: RTL

//  Instruction-fetch stage directly upstream of instruction memory. Holds the PC and drives im_addr.

---
 rtl/if_stage_if.sv | 55 +++++
 rtl/if_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
//  Bundles the instruction-memory, redirect and decode-handshake signals of
//  the fetch stage.
//
//  Signals
//   im_addr        fetch address toward instruction memory
//   im_data        instruction word for im_addr, valid in the same cycle
//   redirect_valid one-cycle request to change fetch flow
//   redirect_pc    redirect target
//   id_ready       decode accepts the fetch slot this cycle
//   id_valid       fetch slot holds an instruction
//   id_pc          PC of the slot instruction
//   id_inst        instruction word of the slot
//   id_exc         slot carries a fetch address error
//
//  Modports
//   master  the fetch stage itself
//   slave   the surroundings (memory, branch unit, decode)
// ----------------------------------------------------------------------------
interface if_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_exc;

    modport master (
        output im_addr,
        input  im_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output id_pc,
        output id_inst,
        output id_exc
    );

    modport slave (
        input  im_addr,
        output im_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        input  id_exc
    );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//  Instruction-fetch stage sitting directly in front of instruction memory.
//  Holds the PC (driven out as im_addr), registers the combinational im_data
//  into a single fetch slot handed to decode with valid/ready, applies branch
//  and jump redirects (buffering one that arrives while the stage cannot
//  advance), and traps misaligned or unmapped fetch addresses.
//
//  Ports
//   clk     clock, all state updates on the rising edge
//   resetn  synchronous reset, active low
//   bus     if_stage_if.master: im_addr/im_data, redirect_valid/redirect_pc,
//           id_ready, id_valid/id_pc/id_inst/id_exc
//
//  Parameters
//   RESET_PC  PC loaded on reset (boot ROM)
//   REGION_A  addr[31:20] of the first mapped instruction region
//   REGION_B  addr[31:20] of the second mapped instruction region
//   NOP_INST  instruction word emitted with id_exc
//
//  Configuration
//   IF_DELAY_SLOT_EN  when defined, the instruction fetched on the edge that
//                     takes a redirect (the delay slot) is delivered to
//                     decode; when undefined it is squashed (id_valid=0) and
//                     an address fault in it is ignored.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  BOOT  | first cycle after reset, nothing captured
//  RUN   | fetching; one instruction captured on every advance cycle
//  FAULT | fetch halted after an address error, waits for a redirect
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h9fc0_0000,
    parameter logic [11:0] REGION_A = 12'h9fc,
    parameter logic [11:0] REGION_B = 12'h800,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    if_stage_if.master  bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state,      state_nxt;
    logic [31:0] pc,         pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_pc,    pend_pc_nxt;
    logic        id_valid,   id_valid_nxt;
    logic [31:0] id_pc,      id_pc_nxt;
    logic [31:0] id_inst,    id_inst_nxt;
    logic        id_exc,     id_exc_nxt;

    logic        adv;
    logic        bad;
    logic        eff;
    logic [31:0] eff_pc;
    logic        squash;

    assign adv    = (state == RUN) && (!id_valid || bus.id_ready);
    assign bad    = (pc[1:0] != 2'b00) ||
                    ((pc[31:20] != REGION_A) && (pc[31:20] != REGION_B));
    // A live redirect takes priority over one buffered during a stall.
    assign eff    = bus.redirect_valid | pend_valid;
    assign eff_pc = bus.redirect_valid ? bus.redirect_pc : pend_pc;

`ifdef IF_DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    // The instruction fetched alongside a taken redirect is the wrong path.
    assign squash = eff;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
            id_valid   <= 1'b0;
            id_pc      <= 32'h0;
            id_inst    <= 32'h0;
            id_exc     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            id_valid   <= id_valid_nxt;
            id_pc      <= id_pc_nxt;
            id_inst    <= id_inst_nxt;
            id_exc     <= id_exc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        id_valid_nxt   = id_valid;
        id_pc_nxt      = id_pc;
        id_inst_nxt    = id_inst;
        id_exc_nxt     = id_exc;

        case (state)
            BOOT: begin
                state_nxt = RUN;
                if (bus.redirect_valid) begin
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = bus.redirect_pc;
                end
            end

            RUN: begin
                if (adv) begin
                    id_pc_nxt      = pc;
                    id_inst_nxt    = bad ? NOP_INST : bus.im_data;
                    id_exc_nxt     = bad && !squash;
                    id_valid_nxt   = !squash;
                    // pc+4 wraps silently; the wrapped address traps via bad.
                    pc_nxt         = eff ? eff_pc : pc + 32'd4;
                    pend_valid_nxt = 1'b0;
                    if (bad && !squash)
                        state_nxt = FAULT;
                end else if (bus.redirect_valid) begin
                    // Newest redirect overwrites any older buffered one.
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = bus.redirect_pc;
                end
            end

            FAULT: begin
                // Redirects are applied directly here rather than buffered.
                if (eff) begin
                    pc_nxt         = eff_pc;
                    pend_valid_nxt = 1'b0;
                    state_nxt      = RUN;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase

        // Decode drained the slot and nothing replaced it.
        if (!adv && bus.id_ready && id_valid)
            id_valid_nxt = 1'b0;
    end

    assign bus.im_addr  = pc;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_pc;
    assign bus.id_inst  = id_inst;
    assign bus.id_exc   = id_exc;

endmodule
